// File: rtl/dest_arbiter_if.sv
// rtl/dest_arbiter_if.sv - stream bundle between N source streams, the arbiter and the merged sink
//
// Purpose: groups the per-port target streams and the merged initiator stream.
// Ports (signals):
//   target_tvalid/tready/tlast [NUM_PORTS]  per-port handshake, bit i = port i
//   target_tdata [8*NUM_PORTS]              per-port byte, port i at [8i+7:8i]
//   initiator_tvalid/tready/tlast           merged stream handshake
//   initiator_tdata [8], initiator_tid      merged byte and source index
// Modports: master = arbiter side, slave = sources/sink environment side.
interface dest_arbiter_if #(
  parameter int NUM_PORTS = 8,
  parameter int TID_WIDTH = 3
);
  logic [NUM_PORTS-1:0]   target_tvalid;
  logic [NUM_PORTS-1:0]   target_tready;
  logic [NUM_PORTS-1:0]   target_tlast;
  logic [8*NUM_PORTS-1:0] target_tdata;
  logic                   initiator_tvalid;
  logic                   initiator_tready;
  logic                   initiator_tlast;
  logic [7:0]             initiator_tdata;
  logic [TID_WIDTH-1:0]   initiator_tid;

  modport master (
    input  target_tvalid, target_tlast, target_tdata, initiator_tready,
    output target_tready, initiator_tvalid, initiator_tlast, initiator_tdata, initiator_tid
  );

  modport slave (
    output target_tvalid, target_tlast, target_tdata, initiator_tready,
    input  target_tready, initiator_tvalid, initiator_tlast, initiator_tdata, initiator_tid
  );
endinterface

// File: rtl/dest_arbiter.sv
// rtl/dest_arbiter.sv - packet-atomic N:1 stream arbiter tagging packets with source index on tid
//
// Purpose: merges NUM_PORTS byte streams into one, holding the grant from a
// packet's first beat to its tlast beat; one output register stage.
// Ports:
//   aclk     clock, rising edge
//   aresetn  synchronous active-low reset
//   axis     dest_arbiter_if.master: target_* inputs (ready out), initiator_* outputs
// Configuration macro: DEST_ARBITER_RR_EN - defined: round-robin from a priority
// pointer; undefined: fixed priority, lowest index wins, no pointer register.
module dest_arbiter #(
  parameter int NUM_PORTS = 8,
  parameter int TID_WIDTH = 3
) (
  input  logic            aclk,
  input  logic            aresetn,
  dest_arbiter_if.master  axis
);
  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

  state_t               state_q;
  logic [IW-1:0]        gnt_q;
  logic                 out_valid_q;
  logic                 out_last_q;
  logic [7:0]           out_data_q;
  logic [TID_WIDTH-1:0] out_tid_q;
`ifdef DEST_ARBITER_RR_EN
  logic [IW-1:0]        ptr_q;
  logic [IW:0]          cand;
`endif

  logic                 can_load;
  logic                 win_found;
  logic [IW-1:0]        win_idx;
  logic [IW-1:0]        sel_idx;
  logic                 sel_active;
  logic                 sel_valid;
  logic                 sel_last;
  logic [7:0]           sel_data;
  logic                 accept;
  logic [NUM_PORTS-1:0] ready_vec;

`ifdef DEST_ARBITER_RR_EN
  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    return (i == IW'(NUM_PORTS - 1)) ? '0 : i + IW'(1);
  endfunction
`endif

  // Winner among asserted valids; only consulted while IDLE.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef DEST_ARBITER_RR_EN
    cand      = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NUM_PORTS)) cand = cand - (IW+1)'(NUM_PORTS);
      if (!win_found && axis.target_tvalid[cand[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IW-1:0];
      end
    end
`else
    // Scan downwards so the lowest asserted index is the last to overwrite.
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (axis.target_tvalid[IW'(k)]) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
`endif
  end

  assign can_load = !out_valid_q || axis.initiator_tready;

  // While LOCKED the granted port keeps ready even through idle gaps, so ready
  // never depends on that port's own valid.
  always_comb begin
    sel_idx    = (state_q == ST_LOCKED) ? gnt_q : win_idx;
    sel_active = (state_q == ST_LOCKED) || win_found;
    sel_valid  = axis.target_tvalid[sel_idx];
    sel_last   = axis.target_tlast[sel_idx];
    sel_data   = axis.target_tdata[{sel_idx, 3'b000} +: 8];
    ready_vec  = '0;
    if (aresetn && sel_active && can_load) ready_vec[sel_idx] = 1'b1;
    accept     = aresetn && sel_active && can_load && sel_valid;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      out_tid_q   <= '0;
`ifdef DEST_ARBITER_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      if (can_load) begin
        out_valid_q <= accept;
        if (accept) begin
          out_last_q <= sel_last;
          out_data_q <= sel_data;
          out_tid_q  <= TID_WIDTH'(sel_idx);
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (!sel_last) begin
              state_q <= ST_LOCKED;
              gnt_q   <= sel_idx;
            end else begin
`ifdef DEST_ARBITER_RR_EN
              ptr_q <= next_idx(sel_idx);
`endif
            end
          end
        end
        ST_LOCKED: begin
          if (accept && sel_last) begin
            state_q <= ST_IDLE;
`ifdef DEST_ARBITER_RR_EN
            ptr_q   <= next_idx(gnt_q);
`endif
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign axis.target_tready    = ready_vec;
  assign axis.initiator_tvalid = out_valid_q;
  assign axis.initiator_tlast  = out_last_q;
  assign axis.initiator_tdata  = out_data_q;
  assign axis.initiator_tid    = out_tid_q;
endmodule
